// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding and grant encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SW = 4;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // One master's request-side signals, bundled so the top can mux them as a unit.
  typedef struct packed {
    logic [WB_DW-1:0] dat;
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module wb_rr_pick2
  import wb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_gnt,
  output logic [1:0] gnt
);

  // Pick one-hot winner from the request pair and the previous winner.
  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_M0;
      2'b10:   gnt = GNT_M1;
      2'b11:   gnt = (last_gnt == GNT_M0) ? GNT_M1 : GNT_M0;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant and per-transaction timeout.
// Latency: request sampled at edge N reaches the slave in cycle N+1; ack/data pass through combinationally.
// Backpressure: the losing master simply waits; a silent slave is cut off with err after TIMEOUT_CYC cycles.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WB_DW-1:0] m0_wb_dat_i,
  input  logic [WB_AW-1:0] m0_wb_adr_i,
  input  logic [WB_SW-1:0] m0_wb_sel_i,
  input  logic             m0_wb_we_i,
  input  logic             m0_wb_cyc_i,
  input  logic             m0_wb_stb_i,
  output logic [WB_DW-1:0] m0_wb_dat_o,
  output logic             m0_wb_ack_o,
  output logic             m0_wb_err_o,
  input  logic [WB_DW-1:0] m1_wb_dat_i,
  input  logic [WB_AW-1:0] m1_wb_adr_i,
  input  logic [WB_SW-1:0] m1_wb_sel_i,
  input  logic             m1_wb_we_i,
  input  logic             m1_wb_cyc_i,
  input  logic             m1_wb_stb_i,
  output logic [WB_DW-1:0] m1_wb_dat_o,
  output logic             m1_wb_ack_o,
  output logic             m1_wb_err_o,
  output logic [WB_DW-1:0] s_wb_dat_o,
  output logic [WB_AW-1:0] s_wb_adr_o,
  output logic [WB_SW-1:0] s_wb_sel_o,
  output logic             s_wb_we_o,
  output logic             s_wb_cyc_o,
  output logic             s_wb_stb_o,
  input  logic [WB_DW-1:0] s_wb_dat_i,
  input  logic             s_wb_ack_i,
  output logic             timeout_o,
  output logic [1:0]       gnt_o
);

  // Last BUSY cycle index before the slave is declared hung.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       last_gnt_q;
  logic [CNT_W-1:0] cnt_q;

  wb_req_t    m0_req, m1_req, g_req;
  logic [1:0] req;
  logic [1:0] pick;
  logic       busy;
  logic       tmo_hit;

  assign m0_req = '{dat: m0_wb_dat_i, adr: m0_wb_adr_i, sel: m0_wb_sel_i,
                    we: m0_wb_we_i, cyc: m0_wb_cyc_i, stb: m0_wb_stb_i};
  assign m1_req = '{dat: m1_wb_dat_i, adr: m1_wb_adr_i, sel: m1_wb_sel_i,
                    we: m1_wb_we_i, cyc: m1_wb_cyc_i, stb: m1_wb_stb_i};

  assign req  = {m1_req.cyc & m1_req.stb, m0_req.cyc & m0_req.stb};
  assign busy = (state_q == ARB_BUSY);

  // Granted master's request; gnt_q is one-hot in BUSY, so bit 1 selects M1.
  assign g_req = gnt_q[1] ? m1_req : m0_req;

  // Timeout only when the slave stays silent and the master is still holding the cycle;
  // an ack in the same cycle takes precedence.
  assign tmo_hit = busy & ~s_wb_ack_i & g_req.cyc & (cnt_q == CNT_LAST);

  wb_rr_pick2 u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (pick)
  );

  // Slave-side mux: everything is held at zero outside BUSY so reset and IDLE look identical.
  always_comb begin
    s_wb_dat_o = '0;
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    if (busy) begin
      s_wb_dat_o = g_req.dat;
      s_wb_adr_o = g_req.adr;
      s_wb_sel_o = g_req.sel;
      s_wb_we_o  = g_req.we;
      s_wb_cyc_o = g_req.cyc;
      s_wb_stb_o = g_req.stb & ~tmo_hit;
    end
  end

  // Master-side return path: only the granted master sees slave data, ack or err.
  always_comb begin
    m0_wb_dat_o = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    if (busy && gnt_q == GNT_M0) begin
      m0_wb_dat_o = s_wb_dat_i;
      m0_wb_ack_o = s_wb_ack_i;
      m0_wb_err_o = tmo_hit;
    end
    if (busy && gnt_q == GNT_M1) begin
      m1_wb_dat_o = s_wb_dat_i;
      m1_wb_ack_o = s_wb_ack_i;
      m1_wb_err_o = tmo_hit;
    end
  end

  assign timeout_o = tmo_hit;
  assign gnt_o     = gnt_q;

  // Arbitration FSM: grant from IDLE, leave BUSY on ack, abort or timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= GNT_NONE;
      last_gnt_q <= GNT_M1;   // so M0 wins the first tie after reset
      cnt_q      <= '0;
    end else if (!busy) begin
      if (pick != GNT_NONE) begin
        state_q    <= ARB_BUSY;
        gnt_q      <= pick;
        last_gnt_q <= pick;
        cnt_q      <= '0;
      end
    end else if (s_wb_ack_i || !g_req.cyc || tmo_hit) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_NONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter checked cycle by cycle against a transaction-owner model.
// Latency: n/a.
// Backpressure: slave ack policy rotates between random, hung and last-cycle-ack phases.
module tb_wb_arbiter;

  localparam int T = 8;
  localparam int NCYC = 3000;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [31:0] m_dat[2];
  logic [31:0] m_adr[2];
  logic [3:0]  m_sel[2];
  logic        m_we[2];
  logic        m_cyc[2];
  logic        m_stb[2];
  logic        m_active[2];
  logic        m_done[2];

  logic [31:0] s_wb_dat_i;
  logic        s_wb_ack_i;

  logic [31:0] m0_wb_dat_o, m1_wb_dat_o, s_wb_dat_o, s_wb_adr_o;
  logic        m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_we_o, s_wb_cyc_o, s_wb_stb_o, timeout_o;
  logic [1:0]  gnt_o;

  wb_arbiter #(.TIMEOUT_CYC(T), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0_wb_dat_i (m_dat[0]),
    .m0_wb_adr_i (m_adr[0]),
    .m0_wb_sel_i (m_sel[0]),
    .m0_wb_we_i  (m_we[0]),
    .m0_wb_cyc_i (m_cyc[0]),
    .m0_wb_stb_i (m_stb[0]),
    .m0_wb_dat_o (m0_wb_dat_o),
    .m0_wb_ack_o (m0_wb_ack_o),
    .m0_wb_err_o (m0_wb_err_o),
    .m1_wb_dat_i (m_dat[1]),
    .m1_wb_adr_i (m_adr[1]),
    .m1_wb_sel_i (m_sel[1]),
    .m1_wb_we_i  (m_we[1]),
    .m1_wb_cyc_i (m_cyc[1]),
    .m1_wb_stb_i (m_stb[1]),
    .m1_wb_dat_o (m1_wb_dat_o),
    .m1_wb_ack_o (m1_wb_ack_o),
    .m1_wb_err_o (m1_wb_err_o),
    .s_wb_dat_o  (s_wb_dat_o),
    .s_wb_adr_o  (s_wb_adr_o),
    .s_wb_sel_o  (s_wb_sel_o),
    .s_wb_we_o   (s_wb_we_o),
    .s_wb_cyc_o  (s_wb_cyc_o),
    .s_wb_stb_o  (s_wb_stb_o),
    .s_wb_dat_i  (s_wb_dat_i),
    .s_wb_ack_i  (s_wb_ack_i),
    .timeout_o   (timeout_o),
    .gnt_o       (gnt_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who owns the slave (0 none, 1 M0, 2 M1), how long, and who won last.
  int owner, age, last;
  logic        e_busy, e_gcyc, e_gstb, e_tmo;
  logic        e_ack[2], e_err[2];
  logic [31:0] e_mdat[2];
  logic [31:0] e_sdat, e_sadr;
  logic [3:0]  e_ssel;
  logic        e_swe, e_scyc, e_sstb;
  logic [1:0]  e_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    age   = 0;
    last  = 1;
  endtask

  task automatic compute_exp();
    int k;
    k      = (owner == 0) ? 0 : owner - 1;
    e_busy = (owner != 0);
    e_gcyc = e_busy && m_cyc[k];
    e_gstb = e_busy && m_stb[k];
    e_tmo  = e_busy && !s_wb_ack_i && e_gcyc && (age == T - 1);
    e_scyc = e_gcyc;
    e_sstb = e_gstb && !e_tmo;
    e_sdat = e_busy ? m_dat[k] : 32'h0;
    e_sadr = e_busy ? m_adr[k] : 32'h0;
    e_ssel = e_busy ? m_sel[k] : 4'h0;
    e_swe  = e_busy && m_we[k];
    e_gnt  = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    for (int j = 0; j < 2; j++) begin
      e_ack[j]  = e_busy && (k == j) && s_wb_ack_i;
      e_err[j]  = e_busy && (k == j) && e_tmo;
      e_mdat[j] = (e_busy && k == j) ? s_wb_dat_i : 32'h0;
    end
  endtask

  // Advance the model across one clock edge using the inputs present just before it.
  task automatic model_step();
    logic r0, r1;
    compute_exp();
    if (e_busy) begin
      if (s_wb_ack_i || !e_gcyc || e_tmo) owner = 0;
      else age++;
    end else begin
      r0 = m_cyc[0] && m_stb[0];
      r1 = m_cyc[1] && m_stb[1];
      if (r0 && r1) begin
        owner = (last == 1) ? 1 : 2;
      end else if (r0) begin
        owner = 1;
      end else if (r1) begin
        owner = 2;
      end
      if (owner != 0) begin
        last = owner - 1;
        age  = 0;
      end
    end
  endtask

  task automatic compare_all();
    compute_exp();
    check("s_cyc", 32'(s_wb_cyc_o), 32'(e_scyc));
    check("s_stb", 32'(s_wb_stb_o), 32'(e_sstb));
    check("s_dat", s_wb_dat_o, e_sdat);
    check("s_adr", s_wb_adr_o, e_sadr);
    check("s_sel", 32'(s_wb_sel_o), 32'(e_ssel));
    check("s_we", 32'(s_wb_we_o), 32'(e_swe));
    check("m0_ack", 32'(m0_wb_ack_o), 32'(e_ack[0]));
    check("m0_err", 32'(m0_wb_err_o), 32'(e_err[0]));
    check("m0_dat", m0_wb_dat_o, e_mdat[0]);
    check("m1_ack", 32'(m1_wb_ack_o), 32'(e_ack[1]));
    check("m1_err", 32'(m1_wb_err_o), 32'(e_err[1]));
    check("m1_dat", m1_wb_dat_o, e_mdat[1]);
    check("timeout", 32'(timeout_o), 32'(e_tmo));
    check("gnt", 32'(gnt_o), 32'(e_gnt));
  endtask

  task automatic start_txn(input int k);
    m_active[k] = 1'b1;
    m_cyc[k]    = 1'b1;
    m_stb[k]    = 1'b1;
    m_adr[k]    = $urandom;
    m_dat[k]    = $urandom;
    m_sel[k]    = 4'($urandom);
    m_we[k]     = 1'($urandom);
    m_done[k]   = 1'b0;
  endtask

  task automatic stop_txn(input int k);
    m_active[k] = 1'b0;
    m_cyc[k]    = 1'b0;
    m_stb[k]    = 1'b0;
    m_done[k]   = 1'b0;
  endtask

  initial begin
    bit did_rst;
    int mode;
    did_rst = 0;
    rst_ni  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      stop_txn(k);
      m_adr[k] = '0;
      m_dat[k] = '0;
      m_sel[k] = '0;
      m_we[k]  = 1'b0;
    end
    s_wb_dat_i = 32'hDEAD_BEEF;
    s_wb_ack_i = 1'b0;
    model_reset();
    #12;
    compare_all();          // reset state, with the slave driving nonzero data
    #5 rst_ni = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk_i);
      if (rst_ni) model_step();
      else model_reset();
      #1;
      if (!rst_ni) begin
        // Release with both masters requesting: M0 must win the first tie.
        rst_ni = 1'b1;
        start_txn(0);
        start_txn(1);
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (m_active[k] && m_done[k]) stop_txn(k);
          else if (m_active[k] && ($urandom % 60) == 0) stop_txn(k);
          else if (!m_active[k] && ($urandom % 3) == 0) start_txn(k);
        end
      end
      s_wb_dat_i = $urandom;
      compute_exp();
      mode = (cyc / 300) % 3;
      case (mode)
        0:       s_wb_ack_i = e_gstb && (($urandom % 3) == 0);
        1:       s_wb_ack_i = 1'b0;
        default: s_wb_ack_i = e_gstb && (age == T - 1);
      endcase
      @(negedge clk_i);
      compare_all();
      for (int k = 0; k < 2; k++) m_done[k] = e_ack[k] | e_err[k];

      // Asynchronous reset in the middle of an M1 transaction.
      if (!did_rst && cyc > 1000 && owner == 2 && m_cyc[1]) begin
        did_rst = 1;
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int k = 0; k < 2; k++) m_done[k] = 1'b0;
      end
    end

    if (!did_rst) check("reset_injected", 32'(did_rst), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
